// File: rtl/stack_ctrl_if.sv
// Operation/status bundle between the opcode decoder (master) and stack_ctrl (slave).
interface stack_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             op_en;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output op_en, op, din,
    input  dout, count, full, empty, overflow, underflow
  );

  modport slave (
    input  op_en, op, din,
    output dout, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// Parametrised LIFO stack: push/pop/replace-top/clear, one-cycle latency, full/empty/error status.
// STACK_ERR_STICKY_EN makes overflow/underflow hold until rst instead of pulsing for one cycle.
module stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  stack_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_REPLACE = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [CW-1:0]    top_idx;
  logic             full_w, empty_w;

  assign top_idx = count_q - CW'(1);
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
`ifdef STACK_ERR_STICKY_EN
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`else
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
`endif
    // Memory write is gated by rst here because the storage array itself has no reset.
    if (bus.op_en && !rst) begin
      case (bus.op)
        OP_PUSH: begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            waddr   = count_q[AW-1:0];
            count_d = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = mem_q[top_idx[AW-1:0]];
            count_d = top_idx;
          end
        end
        OP_REPLACE: begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            dout_d = mem_q[top_idx[AW-1:0]];
            we     = 1'b1;
            waddr  = top_idx[AW-1:0];
          end
        end
        OP_CLEAR: begin
          count_d = '0;
          dout_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= bus.din;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
